mult_share_arb: RTL

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mult_share_arb.sv
// Two requesters time-share one unsigned WIDTH x WIDTH multiplier through an IDLE/CALC/DONE handshake.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mult_share_arb #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   opA_q, opA_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic               owner_q, owner_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] mulOut;
  logic               anyReq;
  logic               grantEn;
  logic               grantSel;

  assign anyReq  = req0 | req1;
  assign grantEn = (state_q == IDLE) && anyReq;

`ifdef MULT_ARB_RR_EN
  // prio_q high means requester 1 wins the next simultaneous contention
  logic prio_q, prio_d;

  assign grantSel = (req0 && req1) ? prio_q : req1;

  always_comb begin
    prio_d = prio_q;
    if (grantEn) begin
      prio_d = !grantSel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign grantSel = !req0;
`endif

  // The single shared multiplier only ever sees the latched operands
  assign mulOut = (2*WIDTH)'(opA_q) * (2*WIDTH)'(opB_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack0 = (state_q == DONE) && !owner_q;
    ack1 = (state_q == DONE) && owner_q;
    busy = (state_q != IDLE);
  end

  always_comb begin
    opA_d     = opA_q;
    opB_d     = opB_q;
    owner_d   = owner_q;
    product_d = product_q;
    if (grantEn) begin
      opA_d   = grantSel ? a1 : a0;
      opB_d   = grantSel ? b1 : b0;
      owner_d = grantSel;
    end
    if (state_q == CALC) begin
      product_d = mulOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q     <= '0;
      opB_q     <= '0;
      owner_q   <= 1'b0;
      product_q <= '0;
    end else begin
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      owner_q   <= owner_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
